// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - RV32I multicycle control FSM (lw, sw, R/I ALU, beq, jal)
// Optional HALT state and illegal output enabled by defining MC_ILLEGAL_TRAP_EN.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [2:0] alu_control,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic       reg_write
`ifdef MC_ILLEGAL_TRAP_EN
  ,
  output logic       illegal
`endif
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL
`ifdef MC_ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_t;

  state_t     state;
  logic [1:0] alu_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_R:         state <= S_EXECUTER;
            OP_I:         state <= S_EXECUTEI;
            OP_BEQ:       state <= S_BEQ;
            OP_JAL:       state <= S_JAL;
`ifdef MC_ILLEGAL_TRAP_EN
            default:      state <= S_HALT;
`else
            default:      state <= S_FETCH;
`endif
          endcase
        end
        // op[5] separates sw (store) from lw inside the memory class
        S_MEMADR:   state <= op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  state <= S_MEMWB;
        S_EXECUTER: state <= S_ALUWB;
        S_EXECUTEI: state <= S_ALUWB;
        S_JAL:      state <= S_ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
        S_HALT:     state <= S_HALT;
`endif
        default:    state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    reg_write  = 1'b0;
    alu_op     = 2'b00;
`ifdef MC_ILLEGAL_TRAP_EN
    illegal    = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = zero;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      S_HALT:     illegal = 1'b1;
`endif
      default: ;
    endcase
  end

  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - randomized self-checking bench for mc_controller
// Expected per-cycle control vectors come from an instruction-level model.
module tb_mc_controller;
  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic       illegal_o;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .result_src(result_src), .alu_control(alu_control),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .reg_write(reg_write)
`ifdef MC_ILLEGAL_TRAP_EN
    , .illegal(illegal_o)
`endif
  );
`ifndef MC_ILLEGAL_TRAP_EN
  assign illegal_o = 1'b0;
`endif

  always #5 clk = ~clk;

  logic [16:0] obs;
  assign obs = {illegal_o, pc_write, adr_src, mem_write, ir_write, result_src,
                alu_control, alu_src_a, alu_src_b, imm_src, reg_write};

  int total = 0;
  int bad = 0;
  logic [16:0] exp_q [$];
  string name;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011, SLT = 3'b101;

  function automatic logic [16:0] v(input logic ill, input logic pc, input logic adr,
                                    input logic mw, input logic ir, input logic [1:0] rs,
                                    input logic [2:0] alu, input logic [1:0] sa,
                                    input logic [1:0] sb, input logic [1:0] imm,
                                    input logic rw);
    return {ill, pc, adr, mw, ir, rs, alu, sa, sb, imm, rw};
  endfunction

  // ALU operation an R/I instruction is supposed to perform
  function automatic logic [2:0] alu_of(input bit is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0: return (is_r && f7) ? SUB : ADD;
      3'd2: return SLT;
      3'd6: return OR_;
      3'd7: return AND_;
      default: return ADD;
    endcase
  endfunction

  function automatic logic [6:0] op_of(input int cls);
    case (cls)
      0: return 7'b0000011;
      1: return 7'b0100011;
      2: return 7'b0110011;
      3: return 7'b0010011;
      4: return 7'b1100011;
      5: return 7'b1101111;
      default: return 7'b1111111;
    endcase
  endfunction

  // Build the expected cycle-by-cycle control sequence for one instruction
  task automatic build(input int cls);
    logic [1:0] imm;
    logic [16:0] ftch, dcd, wb;
    imm = (cls == 1) ? 2'b01 : (cls == 4) ? 2'b10 : (cls == 5) ? 2'b11 : 2'b00;
    ftch = v(0, 1, 0, 0, 1, 2'b10, ADD, 2'b00, 2'b10, imm, 0);
    dcd  = v(0, 0, 0, 0, 0, 2'b00, ADD, 2'b01, 2'b01, imm, 0);
    wb   = v(0, 0, 0, 0, 0, 2'b00, ADD, 2'b00, 2'b00, imm, 1);
    exp_q = {ftch, dcd};
    case (cls)
      0: begin
        name = "lw";
        exp_q.push_back(v(0, 0, 0, 0, 0, 2'b00, ADD, 2'b10, 2'b01, imm, 0));
        exp_q.push_back(v(0, 0, 1, 0, 0, 2'b00, ADD, 2'b00, 2'b00, imm, 0));
        exp_q.push_back(v(0, 0, 0, 0, 0, 2'b01, ADD, 2'b00, 2'b00, imm, 1));
      end
      1: begin
        name = "sw";
        exp_q.push_back(v(0, 0, 0, 0, 0, 2'b00, ADD, 2'b10, 2'b01, imm, 0));
        exp_q.push_back(v(0, 0, 1, 1, 0, 2'b00, ADD, 2'b00, 2'b00, imm, 0));
      end
      2: begin
        name = "rtype";
        exp_q.push_back(v(0, 0, 0, 0, 0, 2'b00, alu_of(1, funct3, funct7b5), 2'b10, 2'b00, imm, 0));
        exp_q.push_back(wb);
      end
      3: begin
        name = "itype";
        exp_q.push_back(v(0, 0, 0, 0, 0, 2'b00, alu_of(0, funct3, funct7b5), 2'b10, 2'b01, imm, 0));
        exp_q.push_back(wb);
      end
      4: begin
        name = "beq";
        exp_q.push_back(v(0, zero, 0, 0, 0, 2'b00, SUB, 2'b10, 2'b00, imm, 0));
      end
      5: begin
        name = "jal";
        exp_q.push_back(v(0, 1, 0, 0, 0, 2'b00, ADD, 2'b01, 2'b10, imm, 0));
        exp_q.push_back(wb);
      end
      default: begin
        name = "illegal";
`ifdef MC_ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) exp_q.push_back(v(1, 0, 0, 0, 0, 2'b00, ADD, 2'b00, 2'b00, imm, 0));
`endif
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [16:0] e);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic set_instr(input int cls, input logic [2:0] f3, input logic f7, input logic z);
    op = op_of(cls);
    funct3 = f3;
    funct7b5 = f7;
    zero = z;
    build(cls);
  endtask

  // Called just after a clock edge that put the FSM in FETCH
  task automatic run(input int from);
    for (int k = from; k < exp_q.size(); k++) begin
      @(negedge clk);
      check($sformatf("%s_c%0d", name, k), exp_q[k]);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", v(0, 1, 0, 0, 1, 2'b10, ADD, 2'b00, 2'b10, 2'b00, 0));
    @(posedge clk);
    #1 reset = 1'b0;

    set_instr(0, 3'd2, 1'b0, 1'b0); run(0);
    set_instr(1, 3'd2, 1'b0, 1'b0); run(0);
    set_instr(2, 3'd0, 1'b1, 1'b0); run(0);
    set_instr(3, 3'd0, 1'b1, 1'b0); run(0);
    set_instr(2, 3'd2, 1'b0, 1'b1); run(0);
    set_instr(2, 3'd6, 1'b0, 1'b0); run(0);
    set_instr(3, 3'd7, 1'b1, 1'b0); run(0);
    set_instr(4, 3'd0, 1'b0, 1'b1); run(0);
    set_instr(4, 3'd0, 1'b0, 1'b0); run(0);
    set_instr(5, 3'd3, 1'b1, 1'b0); run(0);

    // Asynchronous reset in MEMREAD, then resume from DECODE
    set_instr(0, 3'd2, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("lwrst_c%0d", k), exp_q[k]);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("lwrst_memread", exp_q[3]);
    #1 reset = 1'b1;
    #1 check("async_reset_fetch", exp_q[0]);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    run(1);

`ifndef MC_ILLEGAL_TRAP_EN
    set_instr(6, 3'd0, 1'b0, 1'b0); run(0);
`endif

    for (int n = 0; n < 60; n++) begin
`ifdef MC_ILLEGAL_TRAP_EN
      set_instr($urandom_range(0, 5), 3'($urandom), 1'($urandom), 1'($urandom));
`else
      set_instr($urandom_range(0, 6), 3'($urandom), 1'($urandom), 1'($urandom));
`endif
      run(0);
    end

`ifdef MC_ILLEGAL_TRAP_EN
    set_instr(6, 3'd0, 1'b0, 1'b0); run(0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout total=%0d", total);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Moore-style multicycle control FSM for the RV32I multicycle datapath (regfile, adder, flopr and mux2 instances).
- Sequences fetch, decode, execute, memory and writeback over 3-5 cycles per instruction.
- Drives all datapath mux selects, write enables and ALU control.
- Supported instructions: lw, sw, R-type ALU, I-type ALU, beq, jal.

Parameters:
- none (fixed RV32I subset)

Ports:
- clk  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-high; forces FSM to FETCH
- op  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- pc_write  out  1  PC flopr enable
- adr_src  out  1  memory address: 0=PC, 1=Result
- mem_write  out  1  data memory write enable
- ir_write  out  1  IR and OldPC load enable
- result_src  out  2  00=ALUOut, 01=Data, 10=ALUResult
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- alu_src_a  out  2  00=PC, 01=OldPC, 10=A (rd1 reg)
- alu_src_b  out  2  00=B (rd2 reg), 01=ImmExt, 10=const 4
- imm_src  out  2  00 I, 01 S, 10 B, 11 J; decoded combinationally from op
- reg_write  out  1  regfile we3

Behaviour:
- Clock and reset: clk is the single clock; reset is asynchronous and active-high. Reset (including mid-instruction) puts state in FETCH immediately.
- Output rule: all outputs are combinational from state, op, funct3, funct7b5 and zero. During reset, outputs equal the FETCH values.
- Defaults (any signal not listed for a state): 0.
- FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu add, result_src=10, pc_write=1. Next state: DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, add (branch target into ALUOut). Next state by op:
  - 0000011/0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - other -> see Optional Feature
- MEMADR: alu_src_a=10, alu_src_b=01, add. Next: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: result_src=00, adr_src=1. Next: MEMWB.
- MEMWB: result_src=01, reg_write=1. Next: FETCH.
- MEMWRITE: result_src=00, adr_src=1, mem_write=1. Next: FETCH.
- EXECUTER: alu_src_a=10, alu_src_b=00, ALUOp=10. Next: ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, ALUOp=10. Next: ALUWB.
- ALUWB: result_src=00, reg_write=1. Next: FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, ALUOp=01 (sub), result_src=00; pc_write = zero. Next: FETCH.
- JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1. Next: ALUWB (rd = PC+4).
- ALU decode:
  - ALUOp 00 -> add; ALUOp 01 -> sub.
  - ALUOp 10, by funct3:
    - 000 -> sub if (funct7b5 & op[5]), else add
    - 010 -> slt
    - 110 -> or
    - 111 -> and
    - other -> add
- Latency (cycles): lw 5, sw 4, R/I 4, jal 4, beq 3.
- pc_write is never asserted outside FETCH, BEQ and JAL. Exactly one of reg_write/mem_write/none per instruction.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN
- With it defined:
  - Adds output illegal (1 bit, reset 0) and state HALT.
  - Unknown op in DECODE -> HALT; lw/sw-class op in MEMADR with unexpected op bit 5 pattern is impossible, so no check is needed there.
  - HALT asserts illegal=1, all enables 0, and stays in HALT until reset.
- Without it:
  - Unknown op in DECODE -> FETCH; the instruction is executed as a NOP (PC already advanced).
  - No illegal port.

Test Plan:
- Reset asserted mid-MEMREAD -> state FETCH asynchronously, ir_write=1, pc_write=1, alu_src_b=10 with no clock edge; deassert -> DECODE next edge.
- op=0000011 (lw) -> visits FETCH, DECODE, MEMADR, MEMREAD, MEMWB in 5 cycles; reg_write=1 only in cycle 5 with result_src=01.
- op=0110011, funct3=000, funct7b5=1 -> EXECUTER alu_control=001; same with op=0010011 (addi, funct7b5=1) -> 000.
- op=1100011 with zero=1 -> pc_write=1 in BEQ; with zero=0 -> pc_write=0; both take 3 cycles.
- op=1101111 -> JAL cycle pc_write=1, alu_src_a=01, alu_src_b=10; next ALUWB reg_write=1.
- op=1111111 -> with MC_ILLEGAL_TRAP_EN: HALT, illegal=1 held 10 cycles; without: back to FETCH, no reg_write/mem_write.
